// File: rtl/switch_pkg.sv
// Shared types and constants for the ingress dispatcher and its per-port framers.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package switch_pkg;

    localparam int NUM_PORTS_DEF = 3;

    // Framer state encodings as they appear in the status register.
    localparam logic [1:0] ST_ENC_IDLE    = 2'd0;
    localparam logic [1:0] ST_ENC_PAYLOAD = 2'd1;
    localparam logic [1:0] ST_ENC_DROP    = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE    = ST_ENC_IDLE,
        ST_PAYLOAD = ST_ENC_PAYLOAD,
        ST_DROP    = ST_ENC_DROP
    } port_state_e;

    // Register map. Addresses 1..NUM_PORTS are the per-port data/packet-count slots.
    localparam logic [2:0] ADDR_STATUS = 3'd0;
    localparam logic [2:0] ADDR_DROP   = 3'd4;
    localparam logic [2:0] ADDR_TRUNC  = 3'd5;
    localparam logic [2:0] ADDR_ERR    = 3'd6;
    localparam logic [2:0] ADDR_ABORT  = 3'd7;

endpackage

// File: rtl/ingress_port_fsm.sv
// One length-prefixed packet framer: decides per byte whether it is enqueued.
// Latency: combinational decision; state/rem registered on the accepting edge.
// Backpressure: full at header drops the packet, full mid-payload truncates it.
//
// Ports: byte_vld/byte_dat carry a byte addressed to this port, full is the
// FIFO full flag sampled with the byte, abort forces IDLE. enq and the *_evt
// outputs are single-cycle combinational pulses; state is the registered state.
module ingress_port_fsm
    import switch_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        byte_vld,
    input  logic [7:0]  byte_dat,
    input  logic        full,
    input  logic        abort,
    output logic        enq,
    output port_state_e state,
    output logic        pkt_evt,
    output logic        drop_evt,
    output logic        trunc_evt,
    output logic        err_evt
);

    port_state_e state_q, state_d;
    logic [7:0]  rem_q, rem_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            rem_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        enq       = 1'b0;
        pkt_evt   = 1'b0;
        drop_evt  = 1'b0;
        trunc_evt = 1'b0;
        err_evt   = 1'b0;
        if (abort) begin
            state_d = ST_IDLE;
            rem_d   = 8'd0;
        end else if (byte_vld) begin
            case (state_q)
                ST_IDLE: begin
                    // Header byte: its value is the number of payload bytes that follow.
                    if (byte_dat == 8'd0) begin
                        err_evt = 1'b1;
                    end else begin
                        rem_d = byte_dat;
                        if (full) begin
                            state_d  = ST_DROP;
                            drop_evt = 1'b1;
                        end else begin
                            enq     = 1'b1;
                            state_d = ST_PAYLOAD;
                        end
                    end
                end
                ST_PAYLOAD: begin
                    rem_d = rem_q - 8'd1;
                    if (!full) begin
                        enq = 1'b1;
                        if (rem_q == 8'd1) begin
                            state_d = ST_IDLE;
                            pkt_evt = 1'b1;
                        end
                    end else begin
                        // The rest of a truncated packet is swallowed so the next
                        // header is found at the right byte.
                        trunc_evt = 1'b1;
                        state_d   = (rem_q == 8'd1) ? ST_IDLE : ST_DROP;
                    end
                end
                ST_DROP: begin
                    rem_d = rem_q - 8'd1;
                    if (rem_q == 8'd1) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    rem_d   = 8'd0;
                end
            endcase
        end
    end

    assign state = state_q;

endmodule

// File: rtl/ingress_dispatcher.sv
// Avalon-slave byte dispatcher feeding NUM_PORTS FIFOs through per-port framers.
// Latency: wrreq/din and readdata registered, 1 cycle after the write/read strobe.
// Backpressure: per-FIFO full sampled with each write; packets dropped/truncated.
//
// Ports: clk, reset (async active-low); Avalon chipselect/write/read/address/
// writedata/readdata; full[p-1], wrreq[p-1], din[8p-1:8p-8] for port p.
// Build option INGRESS_STATS_EN adds the statistics counters (addresses 1..6);
// without it only the status register at address 0 reads non-zero.
// Address space limits NUM_PORTS to at most 3.
module ingress_dispatcher
    import switch_pkg::*;
#(
    parameter int NUM_PORTS = NUM_PORTS_DEF,
    parameter int CNT_W     = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   chipselect,
    input  logic                   write,
    input  logic                   read,
    input  logic [2:0]             address,
    input  logic [7:0]             writedata,
    input  logic [NUM_PORTS-1:0]   full,
    output logic [NUM_PORTS-1:0]   wrreq,
    output logic [8*NUM_PORTS-1:0] din,
    output logic [31:0]            readdata
);

    logic wr_en;
    logic rd_en;
    logic abort;

    assign wr_en = chipselect & write;
    assign rd_en = chipselect & read;
    assign abort = wr_en && (address == ADDR_ABORT);

    logic [NUM_PORTS-1:0] enq;
    logic [NUM_PORTS-1:0] pkt_evt;
    logic [NUM_PORTS-1:0] drop_evt;
    logic [NUM_PORTS-1:0] trunc_evt;
    logic [NUM_PORTS-1:0] err_evt;
    port_state_e          port_state [NUM_PORTS];

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        ingress_port_fsm u_fsm (
            .clk       (clk),
            .reset     (reset),
            .byte_vld  (wr_en && (address == 3'(p + 1))),
            .byte_dat  (writedata),
            .full      (full[p]),
            .abort     (abort),
            .enq       (enq[p]),
            .state     (port_state[p]),
            .pkt_evt   (pkt_evt[p]),
            .drop_evt  (drop_evt[p]),
            .trunc_evt (trunc_evt[p]),
            .err_evt   (err_evt[p])
        );
    end

    // FIFO write side. Only one port is addressed per cycle, so enq is one-hot.
    logic [NUM_PORTS-1:0]   wrreq_q, wrreq_d;
    logic [8*NUM_PORTS-1:0] din_q, din_d;

    always_comb begin
        wrreq_d = enq;
        din_d   = din_q;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (enq[p]) begin
                din_d[8*p +: 8] = writedata;
            end
        end
    end

    // Status: full flags in the low bits, then two state bits per framer.
    logic [31:0] status;

    always_comb begin
        status                = 32'd0;
        status[NUM_PORTS-1:0] = full;
        for (int p = 0; p < NUM_PORTS; p++) begin
            status[NUM_PORTS + 2*p +: 2] = port_state[p];
        end
    end

    logic [31:0] rd_val;

`ifdef INGRESS_STATS_EN
    logic [CNT_W-1:0] pkt_cnt_q [NUM_PORTS];
    logic [CNT_W-1:0] pkt_cnt_d [NUM_PORTS];
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic [CNT_W-1:0] trunc_cnt_q, trunc_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    // Saturating increment; a clear takes effect first so a coinciding event counts as 1.
    function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] cur,
                                                  input logic inc, input logic clr);
        logic [CNT_W-1:0] base;
        base = clr ? '0 : cur;
        if (inc && (base != '1)) begin
            return base + 1'b1;
        end
        return base;
    endfunction

    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            pkt_cnt_d[p] = cnt_next(pkt_cnt_q[p], pkt_evt[p], 1'b0);
        end
        drop_cnt_d  = cnt_next(drop_cnt_q,  |drop_evt,  rd_en && (address == ADDR_DROP));
        trunc_cnt_d = cnt_next(trunc_cnt_q, |trunc_evt, rd_en && (address == ADDR_TRUNC));
        err_cnt_d   = cnt_next(err_cnt_q,   |err_evt,   rd_en && (address == ADDR_ERR));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                pkt_cnt_q[p] <= '0;
            end
            drop_cnt_q  <= '0;
            trunc_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                pkt_cnt_q[p] <= pkt_cnt_d[p];
            end
            drop_cnt_q  <= drop_cnt_d;
            trunc_cnt_q <= trunc_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    always_comb begin
        rd_val = 32'd0;
        case (address)
            ADDR_STATUS: rd_val = status;
            ADDR_DROP:   rd_val = 32'(drop_cnt_q);
            ADDR_TRUNC:  rd_val = 32'(trunc_cnt_q);
            ADDR_ERR:    rd_val = 32'(err_cnt_q);
            ADDR_ABORT:  rd_val = 32'd0;
            default: begin
                for (int p = 0; p < NUM_PORTS; p++) begin
                    if (address == 3'(p + 1)) begin
                        rd_val = 32'(pkt_cnt_q[p]);
                    end
                end
            end
        endcase
    end
`else
    // Framer event pulses and the counter width have no consumer in this build.
    logic unused_evt;
    assign unused_evt = ^{pkt_evt, drop_evt, trunc_evt, err_evt};
    localparam int unused_cnt_w = CNT_W;

    always_comb begin
        rd_val = (address == ADDR_STATUS) ? status : 32'd0;
    end
`endif

    logic [31:0] readdata_q, readdata_d;

    always_comb begin
        readdata_d = rd_en ? rd_val : readdata_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wrreq_q    <= '0;
            din_q      <= '0;
            readdata_q <= 32'd0;
        end else begin
            wrreq_q    <= wrreq_d;
            din_q      <= din_d;
            readdata_q <= readdata_d;
        end
    end

    assign wrreq    = wrreq_q;
    assign din      = din_q;
    assign readdata = readdata_q;

endmodule

// File: tb/tb_ingress_dispatcher.sv
// Bench for ingress_dispatcher: directed packet scenarios then random traffic,
// checked against a packet-level reference model (bytes owed, drop flag, counters).
// Counter expectations follow whether INGRESS_STATS_EN is defined for the build.
module tb_ingress_dispatcher;

    localparam int NP   = 3;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;
`ifdef INGRESS_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset;
    logic            chipselect;
    logic            write;
    logic            read;
    logic [2:0]      address;
    logic [7:0]      writedata;
    logic [NP-1:0]   full;
    logic [NP-1:0]   wrreq;
    logic [8*NP-1:0] din;
    logic [31:0]     readdata;

    ingress_dispatcher #(.NUM_PORTS(NP), .CNT_W(CW)) dut (
        .clk        (clk),
        .reset      (reset),
        .chipselect (chipselect),
        .write      (write),
        .read       (read),
        .address    (address),
        .writedata  (writedata),
        .full       (full),
        .wrreq      (wrreq),
        .din        (din),
        .readdata   (readdata)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: per port, payload bytes still owed by the current packet
    // (0 means the next byte is a header) and whether that packet is being discarded.
    int          m_left [NP];
    bit          m_drop [NP];
    int          m_pkt  [NP];
    int          m_dropc;
    int          m_trunc;
    int          m_err;
    logic [7:0]  m_din  [NP];
    logic [31:0] m_rd;

    task automatic chk(string tag, string what, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s %s: observed %h expected %h", tag, what, obs, exp);
        end
    endtask

    function automatic int bump(int v);
        return (v >= CMAX) ? CMAX : v + 1;
    endfunction

    function automatic void model_reset();
        for (int p = 0; p < NP; p++) begin
            m_left[p] = 0;
            m_drop[p] = 1'b0;
            m_pkt[p]  = 0;
            m_din[p]  = 8'h00;
        end
        m_dropc = 0;
        m_trunc = 0;
        m_err   = 0;
        m_rd    = 32'd0;
    endfunction

    function automatic logic [8*NP-1:0] exp_din();
        logic [8*NP-1:0] v;
        for (int p = 0; p < NP; p++) v[8*p +: 8] = m_din[p];
        return v;
    endfunction

    function automatic logic [31:0] model_status();
        logic [31:0] v;
        int code;
        v = 32'(full);
        for (int p = 0; p < NP; p++) begin
            code = (m_left[p] == 0) ? 0 : (m_drop[p] ? 2 : 1);
            v = v | (32'(code) << (NP + 2*p));
        end
        return v;
    endfunction

    function automatic logic [31:0] model_read(logic [2:0] a);
        logic [31:0] v;
        int ai;
        ai = int'(a);
        v  = 32'd0;
        if (ai == 0) v = model_status();
        else if (ai <= NP) v = STATS ? 32'(m_pkt[ai-1]) : 32'd0;
        else if (ai == 4) begin v = STATS ? 32'(m_dropc) : 32'd0; m_dropc = 0; end
        else if (ai == 5) begin v = STATS ? 32'(m_trunc) : 32'd0; m_trunc = 0; end
        else if (ai == 6) begin v = STATS ? 32'(m_err)   : 32'd0; m_err   = 0; end
        return v;
    endfunction

    function automatic logic [NP-1:0] model_write(logic [2:0] a, logic [7:0] d);
        logic [NP-1:0] e;
        int ai;
        int p;
        e  = '0;
        ai = int'(a);
        if (ai == 7) begin
            for (int q = 0; q < NP; q++) begin
                m_left[q] = 0;
                m_drop[q] = 1'b0;
            end
        end else if (ai >= 1 && ai <= NP) begin
            p = ai - 1;
            if (m_left[p] == 0) begin
                if (d == 8'd0) m_err = bump(m_err);
                else begin
                    m_left[p] = int'(d);
                    if (full[p]) begin
                        m_drop[p] = 1'b1;
                        m_dropc   = bump(m_dropc);
                    end else e[p] = 1'b1;
                end
            end else begin
                if (!m_drop[p] && !full[p]) begin
                    e[p] = 1'b1;
                    if (m_left[p] == 1) m_pkt[p] = bump(m_pkt[p]);
                end else if (!m_drop[p]) begin
                    m_trunc   = bump(m_trunc);
                    m_drop[p] = 1'b1;
                end
                m_left[p] = m_left[p] - 1;
                if (m_left[p] == 0) m_drop[p] = 1'b0;
            end
            if (e[p]) m_din[p] = d;
        end
        return e;
    endfunction

    // One bus cycle: drive at the falling edge, check #1 after the next rising edge.
    task automatic op(string tag, bit do_wr, bit do_rd, logic [2:0] a, logic [7:0] d);
        logic [NP-1:0] e;
        @(negedge clk);
        chipselect = do_wr | do_rd;
        write      = do_wr;
        read       = do_rd;
        address    = a;
        writedata  = d;
        e = '0;
        if (do_rd) m_rd = model_read(a);
        if (do_wr) e = model_write(a, d);
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write      = 1'b0;
        read       = 1'b0;
        chk(tag, "wrreq", 32'(wrreq), 32'(e));
        chk(tag, "din", 32'(din), 32'(exp_din()));
        chk(tag, "readdata", readdata, m_rd);
    endtask

    task automatic wr(string tag, logic [2:0] a, logic [7:0] d);
        op(tag, 1'b1, 1'b0, a, d);
    endtask

    task automatic rd(string tag, logic [2:0] a);
        op(tag, 1'b0, 1'b1, a, 8'h00);
    endtask

    // Reset must clear the outputs without waiting for a clock edge.
    task automatic pulse_reset(string tag);
        @(negedge clk);
        reset = 1'b0;
        #1;
        model_reset();
        chk(tag, "wrreq", 32'(wrreq), 32'(0));
        chk(tag, "din", 32'(din), 32'(exp_din()));
        chk(tag, "readdata", readdata, m_rd);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        logic [2:0] a;
        logic [7:0] d;
        bit         w;
        bit         r;

        reset      = 1'b0;
        chipselect = 1'b0;
        write      = 1'b0;
        read       = 1'b0;
        address    = 3'd0;
        writedata  = 8'h00;
        full       = '0;
        model_reset();
        pulse_reset("reset0");
        rd("status_after_reset", 3'd0);

        // 4-byte packet on port 2.
        wr("p2_hdr", 3'd2, 8'h03);
        wr("p2_b0", 3'd2, 8'hAA);
        wr("p2_b1", 3'd2, 8'hBB);
        wr("p2_b2", 3'd2, 8'hCC);
        rd("p2_pkt_cnt", 3'd2);
        op("idle_hold", 1'b0, 1'b0, 3'd0, 8'h00);

        // Packet dropped at header because port 1 is full.
        full = 3'b001;
        wr("drop_hdr", 3'd1, 8'h02);
        rd("drop_status", 3'd0);
        wr("drop_b0", 3'd1, 8'h11);
        wr("drop_b1", 3'd1, 8'h22);
        full = 3'b000;
        rd("drop_idle", 3'd0);
        rd("drop_cnt", 3'd4);
        rd("drop_cnt_clr", 3'd4);

        // Truncation mid-payload on port 3.
        wr("tr_hdr", 3'd3, 8'h04);
        wr("tr_b0", 3'd3, 8'h01);
        wr("tr_b1", 3'd3, 8'h02);
        full = 3'b100;
        wr("tr_b2", 3'd3, 8'h03);
        wr("tr_b3", 3'd3, 8'h04);
        full = 3'b000;
        rd("tr_cnt", 3'd5);
        rd("tr_status", 3'd0);
        rd("tr_pkt_cnt", 3'd3);

        // Zero-length header is an error; the following byte is a new header.
        wr("err_hdr", 3'd1, 8'h00);
        rd("err_cnt", 3'd6);
        wr("err_next_hdr", 3'd1, 8'h01);
        wr("err_next_b0", 3'd1, 8'h55);
        rd("err_pkt_cnt", 3'd1);

        // Soft abort mid-packet, then a fresh packet.
        wr("ab_hdr", 3'd2, 8'h05);
        wr("ab_b0", 3'd2, 8'h66);
        wr("ab_abort", 3'd7, 8'hFF);
        rd("ab_status", 3'd0);
        wr("ab_new_hdr", 3'd2, 8'h01);
        wr("ab_new_b0", 3'd2, 8'h77);
        rd("ab_pkt_cnt", 3'd2);

        // Reset mid-packet.
        wr("rst_hdr", 3'd1, 8'h05);
        wr("rst_b0", 3'd1, 8'h12);
        wr("rst_b1", 3'd1, 8'h34);
        pulse_reset("rst_mid");
        wr("rst_new_hdr", 3'd1, 8'h01);
        wr("rst_new_b0", 3'd1, 8'h11);
        rd("rst_pkt_cnt", 3'd1);

        // Counter saturation.
        for (int i = 0; i < CMAX + 3; i++) wr("sat_err", 3'd1, 8'h00);
        rd("sat_err_cnt", 3'd6);
        rd("sat_err_clr", 3'd6);

        // Random traffic with random backpressure, including simultaneous read+write.
        for (int i = 0; i < 600; i++) begin
            for (int p = 0; p < NP; p++) full[p] = ($urandom_range(0, 3) == 0);
            a = ($urandom_range(0, 15) == 0) ? 3'd7 : 3'($urandom_range(0, 6));
            d = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                            : 8'($urandom_range(0, 4));
            w = ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 2) == 0);
            op("rand", w, r, a, d);
        end
        full = '0;
        for (int i = 0; i < 8; i++) rd("final_rd", 3'(i));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
